// File: rtl/fc_phase_ctrl_pkg.sv
// fc_ctrl_pkg: shared state encoding and default sizing for the FC layer phase sequencer
package fc_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, CLR, MAC, DRAIN, EMIT, DONE} fc_state_t;
    localparam int FC_N_IN    = 64;
    localparam int FC_N_OUT   = 10;
    localparam int FC_ACC_LAT = 63;
endpackage

// File: rtl/fc_phase_ctrl_if.sv
// fc_phase_ctrl_if: input-stream and result handshakes of the FC phase sequencer
//   s_tvalid/s_tlast/s_tready : input vector stream into the controller
//   m_tvalid/m_tlast/m_tready : result handshake out of the controller
//   out_idx                   : neuron index of the presented result
//   master = environment side, slave = controller side
interface fc_phase_ctrl_if import fc_ctrl_pkg::*; #(parameter int AW_OUT = $clog2(FC_N_OUT));
    logic              s_tvalid;
    logic              s_tlast;
    logic              s_tready;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [AW_OUT-1:0] out_idx;
    modport master (output s_tvalid, s_tlast, m_tready, input s_tready, m_tvalid, m_tlast, out_idx);
    modport slave  (input s_tvalid, s_tlast, m_tready, output s_tready, m_tvalid, m_tlast, out_idx);
endinterface

// File: rtl/fc_phase_ctrl_delay_timer.sv
// fc_delay_timer: loadable down-counter; expire is high while the count sits at 0
//   S_AXIS_ACLK/S_AXIS_ARESET : clock, async active-high reset
//   load/load_val             : reload the count
//   expire                    : count has reached 0
module fc_delay_timer #(
    parameter int CNT_W = 8
) (
    input  logic             S_AXIS_ACLK,
    input  logic             S_AXIS_ARESET,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET)
        if (S_AXIS_ARESET) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign expire = cnt == '0;
endmodule

// File: rtl/fc_phase_ctrl.sv
// fc_phase_ctrl: load one input vector, then per neuron clear/MAC/drain/emit the result
//   S_AXIS_ACLK/S_AXIS_ARESET : clock, async active-high reset
//   start/busy/done/err       : frame control and status (err sticky until start)
//   in_wr_en/in_addr          : input-buffer write strobe and address (read address in MAC)
//   wt_addr                   : weight-ROM address, neuron*N_IN + i by accumulation
//   mac_clr/mac_en            : accumulator clear and operand-valid
//   axis                      : input stream and result handshake
module fc_phase_ctrl import fc_ctrl_pkg::*; #(
    parameter int N_IN    = FC_N_IN,
    parameter int N_OUT   = FC_N_OUT,
    parameter int ACC_LAT = FC_ACC_LAT,
    parameter int CNT_W   = 8,
    localparam int AW_IN  = $clog2(N_IN),
    localparam int AW_OUT = N_OUT > 1 ? $clog2(N_OUT) : 1,
    localparam int AW_WT  = $clog2(N_IN * N_OUT)
) (
    input  logic             S_AXIS_ACLK,
    input  logic             S_AXIS_ARESET,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             in_wr_en,
    output logic [AW_IN-1:0] in_addr,
    output logic [AW_WT-1:0] wt_addr,
    output logic             mac_clr,
    output logic             mac_en,
    fc_phase_ctrl_if.slave   axis
);
    fc_state_t         state;
    logic [AW_OUT-1:0] neuron;
    logic              in_last, n_last, drain_exp;

    assign in_last       = in_addr == AW_IN'(N_IN - 1);
    assign n_last        = neuron == AW_OUT'(N_OUT - 1);
    assign busy          = state != IDLE;
    assign done          = state == DONE;
    assign axis.s_tready = state == LOAD;
    assign in_wr_en      = axis.s_tvalid & axis.s_tready;
    assign mac_clr       = state == CLR;
    assign mac_en        = state == MAC;
    assign axis.m_tvalid = state == EMIT;
    assign axis.m_tlast  = state == EMIT && n_last;
    assign axis.out_idx  = neuron;

    // Loaded on the last operand so DRAIN lasts exactly ACC_LAT cycles.
    fc_delay_timer #(.CNT_W(CNT_W)) u_drain (
        .S_AXIS_ACLK  (S_AXIS_ACLK),
        .S_AXIS_ARESET(S_AXIS_ARESET),
        .load         (state == MAC && in_last),
        .load_val     (CNT_W'(ACC_LAT - 1)),
        .expire       (drain_exp)
    );

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state   <= IDLE;
            err     <= 1'b0;
            in_addr <= '0;
            wt_addr <= '0;
            neuron  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= LOAD;
                    err     <= 1'b0;
                    in_addr <= '0;
                    wt_addr <= '0;
                    neuron  <= '0;
                end
                LOAD: if (in_wr_en) begin
                    // tlast early aborts the frame; tlast missing on the final beat only flags it
                    in_addr <= (in_last || axis.s_tlast) ? '0 : in_addr + 1'b1;
                    if (in_last || axis.s_tlast) state <= in_last ? CLR : IDLE;
                    if (in_last != axis.s_tlast) err <= 1'b1;
                end
                CLR: state <= MAC;
                MAC: begin
                    in_addr <= in_last ? '0 : in_addr + 1'b1;
                    wt_addr <= wt_addr + 1'b1;
                    if (in_last) state <= DRAIN;
                end
                DRAIN: if (drain_exp) state <= EMIT;
                EMIT: if (axis.m_tready) begin
                    state <= n_last ? DONE : CLR;
                    if (!n_last) neuron <= neuron + 1'b1;
                end
                DONE: begin
                    state   <= IDLE;
                    wt_addr <= '0;
                    neuron  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_phase_ctrl.sv
// tb_fc_phase_ctrl: directed checks of the FC phase sequencer with N_IN=4, N_OUT=2, ACC_LAT=3
module tb_fc_phase_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, err, in_wr_en, mac_clr, mac_en;
    logic [1:0] in_addr;
    logic [2:0] wt_addr;
    int         n_chk = 0;
    int         n_bad = 0;

    fc_phase_ctrl_if #(.AW_OUT(1)) bus ();

    fc_phase_ctrl #(.N_IN(4), .N_OUT(2), .ACC_LAT(3), .CNT_W(8)) dut (
        .S_AXIS_ACLK  (clk),
        .S_AXIS_ARESET(rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .in_wr_en     (in_wr_en),
        .in_addr      (in_addr),
        .wt_addr      (wt_addr),
        .mac_clr      (mac_clr),
        .mac_en       (mac_en),
        .axis         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input string tag);
        chk(tag, {busy, done, err, bus.s_tready, in_wr_en, mac_clr, mac_en, bus.m_tvalid,
                  bus.m_tlast, in_addr, wt_addr, bus.out_idx}, 0);
    endtask

    task automatic begin_frame;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_rdy", bus.s_tready, 1);
        chk("start_err", err, 0);
    endtask

    task automatic load(input int nb, input int last_at, input bit gap);
        for (int k = 0; k < nb; k++) begin
            if (gap && k == 2) begin
                bus.s_tvalid = 1'b0;
                #1 chk("gap_wr", in_wr_en, 0);
                tick;
                chk("gap_addr", in_addr, 2);
            end
            bus.s_tvalid = 1'b1;
            bus.s_tlast  = (k == last_at);
            #1 chk("ld_wr", in_wr_en, 1);
            chk("ld_addr", in_addr, k);
            tick;
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic neuron(input int n, input int stall, input bit poke);
        bus.m_tready = (stall == 0);
        chk("clr", {mac_clr, busy, mac_en}, 3'b110);
        tick;
        for (int i = 0; i < 4; i++) begin
            if (poke) start = (i == 1);
            chk("mac_en", mac_en, 1);
            chk("mac_in", in_addr, i);
            chk("mac_wt", wt_addr, (n * 4 + i) % 8);
            tick;
        end
        start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("drain", {mac_en, mac_clr, bus.m_tvalid, busy}, 4'b0001);
            tick;
        end
        for (int s = 0; s < stall; s++) begin
            chk("hold", {bus.m_tvalid, bus.m_tlast, bus.out_idx}, {1'b1, 1'(n == 1), 1'(n)});
            tick;
        end
        bus.m_tready = 1'b1;
        chk("emit", {bus.m_tvalid, bus.m_tlast, bus.out_idx}, {1'b1, 1'(n == 1), 1'(n)});
        tick;
    endtask

    task automatic done_chk;
        chk("done", {done, busy, bus.m_tvalid}, 3'b110);
        tick;
        chk("idle", {done, busy}, 0);
        chk("wt_zero", wt_addr, 0);
    endtask

    initial begin
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.m_tready = 1'b0;
        #12 quiet("reset");
        #10 rst = 1'b0;
        tick;

        // nominal frame with one input gap
        begin_frame;
        load(4, 3, 1);
        neuron(0, 0, 0);
        neuron(1, 0, 0);
        done_chk;
        chk("nom_err", err, 0);

        // early tlast aborts to IDLE
        begin_frame;
        load(2, 1, 0);
        chk("early_err", err, 1);
        chk("early_idle", {busy, bus.s_tready, in_addr}, 0);
        for (int c = 0; c < 6; c++) begin
            chk("early_quiet", {mac_en, mac_clr, done, busy}, 0);
            tick;
        end

        // missing tlast flags err but finishes; start during MAC is ignored
        begin_frame;
        load(4, -1, 0);
        chk("miss_err", err, 1);
        neuron(0, 0, 1);
        neuron(1, 0, 0);
        done_chk;
        chk("miss_err_end", err, 1);

        // backpressure on the first result
        begin_frame;
        load(4, 3, 0);
        neuron(0, 5, 0);
        neuron(1, 0, 0);
        done_chk;

        // async reset in the middle of neuron 1 drain
        begin_frame;
        load(4, 3, 0);
        neuron(0, 0, 0);
        for (int c = 0; c < 6; c++) tick;
        chk("pre_rst", {busy, mac_en, bus.m_tvalid, bus.out_idx}, 4'b1001);
        #2 rst = 1'b1;
        #1 quiet("async_rst");
        #3 rst = 1'b0;
        tick;
        quiet("post_rst");
        begin_frame;
        load(4, 3, 0);
        neuron(0, 0, 0);
        neuron(1, 0, 0);
        done_chk;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/fc_phase_ctrl.md
# fc_phase_ctrl

Phase sequencer for the fully-connected layer engine. It accepts one input vector over an AXI-Stream slave into the input buffer. For each output neuron it clears the accumulator, streams N_IN multiply-accumulate operations with matching input-buffer and weight-ROM addresses, and waits a programmable drain interval for the MAC pipeline to settle. It then presents the result index on an AXI-Stream-style master handshake. It replaces the fixed free-running settle counters with one explicitly sequenced delay, and sits between the top-level AXIS wrapper and the MAC/buffer datapath.

## Interface
Parameters:
- N_IN, 64: input vector length (beats per frame); ≥2
- N_OUT, 10: output neurons per frame; ≥1
- ACC_LAT, 63: MAC pipeline drain cycles after the last operand; ≥1
- CNT_W, 8: drain-counter width; must satisfy ACC_LAT < 2^CNT_W

Ports (AW_IN = $clog2(N_IN), AW_OUT = $clog2(N_OUT), AW_WT = $clog2(N_IN*N_OUT)):
- S_AXIS_ACLK  in  1  sole clock, rising edge
- S_AXIS_ARESET  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result handshake
- err  out  1  sticky framing error; cleared by start or reset
- s_tvalid / s_tlast  in  1 / 1  input stream
- s_tready  out  1  high only in LOAD
- in_wr_en  out  1  = s_tvalid & s_tready
- in_addr  out  AW_IN  input-buffer address (write in LOAD, read in MAC)
- wt_addr  out  AW_WT  weight-ROM address = neuron*N_IN + i
- mac_clr  out  1  accumulator clear
- mac_en  out  1  accumulate enable (operand valid)
- m_tvalid / m_tlast  out  1 / 1  result valid; last neuron of frame
- m_tready  in  1  downstream accept
- out_idx  out  AW_OUT  neuron index of presented result

## Operation
- States: IDLE, LOAD, CLR, MAC, DRAIN, EMIT, DONE.
- IDLE: start=1 clears err and counters, then goes to LOAD.
- LOAD:
  - s_tready=1; each beat writes at in_addr, then in_addr increments.
  - s_tlast on beat k < N_IN−1: set err, go to IDLE (frame aborted, no done).
  - Beat N_IN−1 without s_tlast: set err, proceed anyway.
  - Beat N_IN−1 ends LOAD and goes to CLR; in_addr wraps to 0.
- CLR: mac_clr=1 for one cycle, then MAC.
- MAC:
  - mac_en=1 for exactly N_IN consecutive cycles; in_addr steps 0..N_IN−1.
  - wt_addr increments by 1 each operand cycle. It is never computed by multiplication; it carries across neurons without reset.
  - After the last operand, load the drain counter and go to DRAIN.
- DRAIN: count ACC_LAT cycles with mac_en=0, then EMIT.
- EMIT:
  - m_tvalid=1 and out_idx=neuron; m_tlast=1 when neuron==N_OUT−1.
  - Hold all outputs stable until m_tready=1.
  - On handshake: the last neuron goes to DONE; otherwise neuron++ and go to CLR.
- DONE: done=1 for one cycle, then IDLE; wt_addr returns to 0.
- start outside IDLE is ignored. s_tvalid outside LOAD is ignored (s_tready=0).
- Reset at any point: all state returns to IDLE immediately. No pending done or m_tvalid survives.

## Timing
- Reset values: every output is 0 (busy, done, err, s_tready, in_wr_en, in_addr, wt_addr, mac_clr, mac_en, m_tvalid, m_tlast, out_idx).
- start at edge t sets busy=1 and s_tready=1 from t+1.
- LOAD takes N_IN accepted beats; s_tvalid gaps stall it without limit.
- Per neuron, with m_tready held high: 1 (CLR) + N_IN (MAC) + ACC_LAT (DRAIN) + 1 (EMIT) cycles.
- done asserts the cycle after the final EMIT handshake. busy falls the cycle after done.
- All outputs are registered or decoded directly from state; there are no combinational paths from inputs to outputs except in_wr_en.

## Structure
- Package fc_ctrl_pkg holds:
  - the state enum (7 states, 3-bit encoding);
  - default constants FC_N_IN=64, FC_N_OUT=10, FC_ACC_LAT=63.
- Sub-module fc_delay_timer is the natural split:
  - ports: load, load_val[CNT_W], expire;
  - loadable down-counter; expire is high in the cycle the count reaches 0;
  - reuse it for the drain count.
- Top level holds the FSM, the in_addr/wt_addr/neuron counters and the err flag.

## Test plan
Use N_IN=4, N_OUT=2, ACC_LAT=3 unless stated.
- Nominal frame:
  - start, then 4 back-to-back beats with tlast on beat 3, m_tready=1.
  - Expect 2 results (out_idx 0,1), each 9 cycles after CLR entry; m_tlast only on idx 1.
  - Expect wt_addr sequence 0..7, then done one cycle after the 2nd handshake; err=0.
- Early tlast: tlast on beat 1 → err=1, return to IDLE, no mac_en, no done.
- Missing tlast: 4 beats with no tlast → err=1, both results still emitted, done pulses.
- Backpressure: m_tready=0 for 5 cycles in EMIT → m_tvalid, out_idx and m_tlast hold stable; next CLR starts the cycle after the handshake.
- Async reset: assert S_AXIS_ARESET mid-DRAIN of neuron 1 → all outputs 0 without waiting for a clock edge. A subsequent start runs a clean frame from wt_addr=0.
- start while busy: pulse start during MAC → no effect on counters or state.
